// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//
// Operand-fetch stage with a register scoreboard. A decoded instruction is
// accepted in EMPTY, and its register numbers are latched. The stage then sits
// in CHECK and drives the register-file read ports until neither source is
// busy and the output slot is free. It then captures both operands together
// with the destination, and marks the destination busy. Write-back results
// pass straight through to the register-file write port and clear the
// matching busy bits.
//
// Ports
//   Clk, Resetb          clock (rising edge) and async active-low reset
//   InValid / InReady    request handshake
//   InRn, InRm, InRd     source A, source B and destination register numbers
//   InRegWr              the request writes InRd
//   RA, RB               register-file read addresses
//   BusA, BusB           combinational register-file read data
//   RW, BusW, RegWr      register-file write port (the file writes on negedge)
//   WbValid, WbRd,
//   WbData               write-back result
//   OutValid / OutReady  operand bundle handshake
//   OutA, OutB           captured operands
//   OutRd, OutRegWr      destination carried with the bundle
//   StallCount           saturating count of cycles stalled on a hazard
// ---------------------------------------------------------------------------
module operand_fetch #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Resetb,
    input  logic              InValid,
    output logic              InReady,
    input  logic [4:0]        InRn,
    input  logic [4:0]        InRm,
    input  logic [4:0]        InRd,
    input  logic              InRegWr,
    output logic [4:0]        RA,
    output logic [4:0]        RB,
    input  logic [DATA_W-1:0] BusA,
    input  logic [DATA_W-1:0] BusB,
    output logic [4:0]        RW,
    output logic [DATA_W-1:0] BusW,
    output logic              RegWr,
    input  logic              WbValid,
    input  logic [4:0]        WbRd,
    input  logic [DATA_W-1:0] WbData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutA,
    output logic [DATA_W-1:0] OutB,
    output logic [4:0]        OutRd,
    output logic              OutRegWr,
    output logic [CNT_W-1:0]  StallCount
);

    typedef enum logic {
        EMPTY = 1'b0,
        CHECK = 1'b1
    } state_t;

    localparam logic [4:0] XZR = 5'd31;

    state_t              state_q, state_d;
    logic [4:0]          latchRn_q, latchRn_d;
    logic [4:0]          latchRm_q, latchRm_d;
    logic [4:0]          latchRd_q, latchRd_d;
    logic                latchRegWr_q, latchRegWr_d;
    logic [31:0]         busy_q, busy_d;
    logic                outValid_q, outValid_d;
    logic [DATA_W-1:0]   outA_q, outA_d;
    logic [DATA_W-1:0]   outB_q, outB_d;
    logic [4:0]          outRd_q, outRd_d;
    logic                outRegWr_q, outRegWr_d;
    logic [CNT_W-1:0]    stallCnt_q, stallCnt_d;

    logic                accept;
    logic [31:0]         wbHit;
    logic [31:0]         effBusy;
    logic                hazard;
    logic                slotFree;
    logic                capture;

    // Write-back goes straight to the register file; it lands on the falling
    // edge, so a read in the same cycle already sees the new value by the
    // next rising edge.
    assign RW    = WbRd;
    assign BusW  = WbData;
    assign RegWr = WbValid;

    // A write-back in flight this cycle cancels the busy bit it targets,
    // letting a waiting consumer capture in the very same cycle.
    always_comb begin
        wbHit    = WbValid ? (32'd1 << WbRd) : 32'd0;
        effBusy  = busy_q & ~wbHit;
        hazard   = effBusy[latchRn_q] | effBusy[latchRm_q];
        slotFree = !outValid_q || OutReady;
        accept   = InValid && (state_q == EMPTY);
        capture  = (state_q == CHECK) && !hazard && slotFree;
    end

    // State register.
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept)  state_d = CHECK;
            CHECK: if (capture) state_d = EMPTY;
            default:            state_d = EMPTY;
        endcase
    end

    // FSM outputs: handshake and register-file read addresses.
    always_comb begin
        InReady = 1'b0;
        RA      = 5'd0;
        RB      = 5'd0;
        if (state_q == EMPTY) begin
            InReady = 1'b1;
        end else begin
            RA = latchRn_q;
            RB = latchRm_q;
        end
    end

    // Datapath next-state: request latch, scoreboard, output bundle, counter.
    // A set of busy[Rd] from a capture is applied after the write-back clear
    // so that the new producer wins over a retiring older one.
    always_comb begin
        latchRn_d    = latchRn_q;
        latchRm_d    = latchRm_q;
        latchRd_d    = latchRd_q;
        latchRegWr_d = latchRegWr_q;
        busy_d       = busy_q;
        outValid_d   = outValid_q;
        outA_d       = outA_q;
        outB_d       = outB_q;
        outRd_d      = outRd_q;
        outRegWr_d   = outRegWr_q;
        stallCnt_d   = stallCnt_q;

        if (accept) begin
            latchRn_d    = InRn;
            latchRm_d    = InRm;
            latchRd_d    = InRd;
            latchRegWr_d = InRegWr;
        end

        if (WbValid && (WbRd != XZR)) begin
            busy_d[WbRd] = 1'b0;
        end

        if ((state_q == CHECK) && hazard && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end

        if (capture) begin
            outValid_d = 1'b1;
            outA_d     = BusA;
            outB_d     = BusB;
            outRd_d    = latchRd_q;
            outRegWr_d = latchRegWr_q;
            if (latchRegWr_q && (latchRd_q != XZR)) begin
                busy_d[latchRd_q] = 1'b1;
            end
        end else if (outValid_q && OutReady) begin
            outValid_d = 1'b0;
        end

        busy_d[XZR] = 1'b0;
    end

    // Datapath registers.
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            latchRn_q    <= 5'd0;
            latchRm_q    <= 5'd0;
            latchRd_q    <= 5'd0;
            latchRegWr_q <= 1'b0;
            busy_q       <= 32'd0;
            outValid_q   <= 1'b0;
            outA_q       <= '0;
            outB_q       <= '0;
            outRd_q      <= 5'd0;
            outRegWr_q   <= 1'b0;
            stallCnt_q   <= '0;
        end else begin
            latchRn_q    <= latchRn_d;
            latchRm_q    <= latchRm_d;
            latchRd_q    <= latchRd_d;
            latchRegWr_q <= latchRegWr_d;
            busy_q       <= busy_d;
            outValid_q   <= outValid_d;
            outA_q       <= outA_d;
            outB_q       <= outB_d;
            outRd_q      <= outRd_d;
            outRegWr_q   <= outRegWr_d;
            stallCnt_q   <= stallCnt_d;
        end
    end

    assign OutValid   = outValid_q;
    assign OutA       = outA_q;
    assign OutB       = outB_q;
    assign OutRd      = outRd_q;
    assign OutRegWr   = outRegWr_q;
    assign StallCount = stallCnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch
//
// Directed bench for operand_fetch. It includes a behavioural register file
// that writes on the falling edge and reads combinationally, with X31 reading
// as zero. Inputs change 1 ns after each rising edge, and outputs are checked
// at that same point.
// ---------------------------------------------------------------------------
module tb_operand_fetch;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 16;

    logic              Clk;
    logic              Resetb;
    logic              InValid;
    logic              InReady;
    logic [4:0]        InRn, InRm, InRd;
    logic              InRegWr;
    logic [4:0]        RA, RB;
    logic [DATA_W-1:0] BusA, BusB;
    logic [4:0]        RW;
    logic [DATA_W-1:0] BusW;
    logic              RegWr;
    logic              WbValid;
    logic [4:0]        WbRd;
    logic [DATA_W-1:0] WbData;
    logic              OutValid;
    logic              OutReady;
    logic [DATA_W-1:0] OutA, OutB;
    logic [4:0]        OutRd;
    logic              OutRegWr;
    logic [CNT_W-1:0]  StallCount;

    logic [DATA_W-1:0] regs [32];

    int checkCount = 0;
    int failCount  = 0;

    operand_fetch #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Resetb(Resetb),
        .InValid(InValid), .InReady(InReady),
        .InRn(InRn), .InRm(InRm), .InRd(InRd), .InRegWr(InRegWr),
        .RA(RA), .RB(RB), .BusA(BusA), .BusB(BusB),
        .RW(RW), .BusW(BusW), .RegWr(RegWr),
        .WbValid(WbValid), .WbRd(WbRd), .WbData(WbData),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutA(OutA), .OutB(OutB), .OutRd(OutRd), .OutRegWr(OutRegWr),
        .StallCount(StallCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register file model: falling-edge write, combinational read, XZR = 0.
    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
    end
    always @(negedge Clk) begin
        if (RegWr && (RW != 5'd31)) regs[RW] = BusW;
    end
    assign BusA = (RA == 5'd31) ? '0 : regs[RA];
    assign BusB = (RB == 5'd31) ? '0 : regs[RB];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rn,
                                 input logic [4:0] rm, input logic [4:0] rd,
                                 input logic rw);
        InValid = v;
        InRn    = rn;
        InRm    = rm;
        InRd    = rd;
        InRegWr = rw;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        Resetb   = 1'b0;
        OutReady = 1'b1;
        WbValid  = 1'b0;
        WbRd     = 5'd0;
        WbData   = '0;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // Reset state
        step();
        step();
        checkOutput("rst_outvalid", 64'(OutValid), 64'd0);
        checkOutput("rst_inready", 64'(InReady), 64'd1);
        checkOutput("rst_stall", 64'(StallCount), 64'd0);
        checkOutput("rst_outa", OutA, 64'd0);
        checkOutput("rst_ra", 64'(RA), 64'd0);
        Resetb = 1'b1;

        // Preload X1 and X2 through the write-back pass-through
        WbValid = 1'b1; WbRd = 5'd1; WbData = 64'h11;
        #1;
        checkOutput("wb_rw", 64'(RW), 64'd1);
        checkOutput("wb_busw", BusW, 64'h11);
        checkOutput("wb_regwr", 64'(RegWr), 64'd1);
        step();
        WbRd = 5'd2; WbData = 64'h22;
        step();
        WbValid = 1'b0;
        #1;
        checkOutput("wb_regwr_off", 64'(RegWr), 64'd0);

        // Basic request: Rn=1 Rm=2 Rd=3 RegWr=1
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
        checkOutput("req1_inready", 64'(InReady), 64'd1);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("req1_check_outvalid", 64'(OutValid), 64'd0);
        checkOutput("req1_check_inready", 64'(InReady), 64'd0);
        checkOutput("req1_ra", 64'(RA), 64'd1);
        checkOutput("req1_rb", 64'(RB), 64'd2);
        step();
        checkOutput("req1_outvalid", 64'(OutValid), 64'd1);
        checkOutput("req1_outa", OutA, 64'h11);
        checkOutput("req1_outb", OutB, 64'h22);
        checkOutput("req1_outrd", 64'(OutRd), 64'd3);
        checkOutput("req1_outregwr", 64'(OutRegWr), 64'd1);
        checkOutput("req1_inready_after", 64'(InReady), 64'd1);

        // RAW hazard on X3, resolved by write-back
        applyStimulus(1'b1, 5'd3, 5'd1, 5'd4, 1'b0);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("haz_accept_outvalid", 64'(OutValid), 64'd0);
        checkOutput("haz_accept_stall", 64'(StallCount), 64'd0);
        step();
        checkOutput("haz_stall1", 64'(StallCount), 64'd1);
        checkOutput("haz_outvalid1", 64'(OutValid), 64'd0);
        step();
        checkOutput("haz_stall2", 64'(StallCount), 64'd2);
        step();
        checkOutput("haz_stall3", 64'(StallCount), 64'd3);
        WbValid = 1'b1; WbRd = 5'd3; WbData = 64'hABCD;
        step();
        WbValid = 1'b0;
        checkOutput("haz_outvalid", 64'(OutValid), 64'd1);
        checkOutput("haz_outa", OutA, 64'hABCD);
        checkOutput("haz_outb", OutB, 64'h11);
        checkOutput("haz_outrd", 64'(OutRd), 64'd4);
        checkOutput("haz_stall_hold", 64'(StallCount), 64'd3);

        // XZR destination is never marked busy
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd31, 1'b1);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        checkOutput("xzr_w_outrd", 64'(OutRd), 64'd31);
        applyStimulus(1'b1, 5'd31, 5'd31, 5'd5, 1'b0);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        checkOutput("xzr_r_outvalid", 64'(OutValid), 64'd1);
        checkOutput("xzr_r_outa", OutA, 64'd0);
        checkOutput("xzr_r_stall", 64'(StallCount), 64'd3);

        // Back-pressure: first bundle held, second request waits
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd6, 1'b0);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        checkOutput("bp_first_outa", OutA, 64'h11);
        OutReady = 1'b0;
        applyStimulus(1'b1, 5'd3, 5'd1, 5'd7, 1'b0);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        checkOutput("bp_hold_outvalid", 64'(OutValid), 64'd1);
        checkOutput("bp_hold_outa", OutA, 64'h11);
        checkOutput("bp_hold_outb", OutB, 64'h22);
        checkOutput("bp_hold_inready", 64'(InReady), 64'd0);
        checkOutput("bp_hold_stall", 64'(StallCount), 64'd3);
        step();
        checkOutput("bp_hold2_outa", OutA, 64'h11);
        checkOutput("bp_hold2_outrd", 64'(OutRd), 64'd6);
        OutReady = 1'b1;
        step();
        checkOutput("bp_second_outvalid", 64'(OutValid), 64'd1);
        checkOutput("bp_second_outa", OutA, 64'hABCD);
        checkOutput("bp_second_outb", OutB, 64'h11);
        checkOutput("bp_second_outrd", 64'(OutRd), 64'd7);
        step();
        checkOutput("bp_drain_outvalid", 64'(OutValid), 64'd0);
        checkOutput("bp_drain_outa_hold", OutA, 64'hABCD);

        // Reset in CHECK with X5 pending
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        applyStimulus(1'b1, 5'd5, 5'd1, 5'd8, 1'b0);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        checkOutput("rst2_pre_stall", 64'(StallCount), 64'd4);
        checkOutput("rst2_pre_inready", 64'(InReady), 64'd0);
        #1;
        Resetb = 1'b0;
        #1;
        checkOutput("rst2_outvalid", 64'(OutValid), 64'd0);
        checkOutput("rst2_stall", 64'(StallCount), 64'd0);
        checkOutput("rst2_inready", 64'(InReady), 64'd1);
        Resetb = 1'b1;
        step();
        checkOutput("rst2_post_inready", 64'(InReady), 64'd1);
        applyStimulus(1'b1, 5'd5, 5'd2, 5'd9, 1'b0);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        checkOutput("rst2_req_outvalid", 64'(OutValid), 64'd1);
        checkOutput("rst2_req_outa", OutA, 64'd0);
        checkOutput("rst2_req_outb", OutB, 64'h22);
        checkOutput("rst2_req_stall", 64'(StallCount), 64'd0);

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
